fifo_pop_demux: RTL

- Consumer stage directly downstream of the 12-bit, 8-entry fifo.
- Pops words from the fifo whenever it is non-empty, enabled and no destination is almost full.
- Decodes the destination field in each word and forwards the word, registered, to one of four downstream fifos via a one-hot push.
- Flags an unrecoverable error if a word targets a destination that is already full.

---
 rtl/fifo_pop_demux_if.sv | 30 +++
 rtl/fifo_pop_demux.sv | 84 ++++++++
 2 files changed

// File: rtl/fifo_pop_demux_if.sv
// Bundle between the pop/demux stage, the upstream fifo and the four destination fifos.
// The slave modport is the demux stage; the master modport is everything around it.
interface fifo_pop_demux_if #(
  parameter int WORD_SIZE = 12,
  parameter int DEST_W    = 2,
  parameter int NUM_DEST  = 1 << DEST_W,
  parameter int CNT_W     = 8
);
  logic                 enable;
  logic [WORD_SIZE-1:0] fifo_data_out;
  logic                 fifo_empty;
  logic [NUM_DEST-1:0]  almost_full_dest;
  logic [NUM_DEST-1:0]  full_dest;
  logic                 fifo_rd;
  logic [NUM_DEST-1:0]  push_out;
  logic [WORD_SIZE-1:0] data_out;
  logic [CNT_W-1:0]     words_fwd;
  logic                 error;
  logic                 idle;

  modport master (
    output enable, fifo_data_out, fifo_empty, almost_full_dest, full_dest,
    input  fifo_rd, push_out, data_out, words_fwd, error, idle
  );

  modport slave (
    input  enable, fifo_data_out, fifo_empty, almost_full_dest, full_dest,
    output fifo_rd, push_out, data_out, words_fwd, error, idle
  );
endinterface

// File: rtl/fifo_pop_demux.sv
// Pops the upstream fifo and steers each word to one of NUM_DEST fifos; fifo_rd -> push is 2 cycles.
// Any almost_full stalls all popping; a word aimed at a full destination is dropped and latches error.
module fifo_pop_demux #(
  parameter int WORD_SIZE = 12,
  parameter int DEST_W    = 2,
  parameter int NUM_DEST  = 1 << DEST_W,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  fifo_pop_demux_if.slave   bus
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_IDLE   = 2'd1,
    S_ACTIVE = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  state_t               state;
  logic                 rd_pending;
  logic [NUM_DEST-1:0]  push_q;
  logic [WORD_SIZE-1:0] data_q;
  logic [CNT_W-1:0]     fwd_q;
  logic                 error_q;

  logic                 rd_c;
  logic [DEST_W-1:0]    dest;
  logic [NUM_DEST-1:0]  dest_onehot;
  logic                 dest_full;
  logic                 drop;

  assign dest        = bus.fifo_data_out[WORD_SIZE-1 -: DEST_W];
  assign dest_onehot = {{(NUM_DEST-1){1'b0}}, 1'b1} << dest;
  assign dest_full   = bus.full_dest[dest];
  assign drop        = rd_pending & dest_full;

  // Two words can be in flight, so almost_full must throttle before the destination is full.
  assign rd_c = (state == S_ACTIVE) & bus.enable & ~bus.fifo_empty & ~(|bus.almost_full_dest);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_RESET;
      rd_pending <= 1'b0;
      push_q     <= '0;
      data_q     <= '0;
      fwd_q      <= '0;
      error_q    <= 1'b0;
    end else begin
      rd_pending <= rd_c;
      push_q     <= '0;

      if (rd_pending) begin
        if (!dest_full) begin
          push_q <= dest_onehot;
          data_q <= bus.fifo_data_out;
          fwd_q  <= fwd_q + CNT_W'(1);
        end else begin
          error_q <= 1'b1;
        end
      end

      case (state)
        S_RESET:  state <= S_IDLE;
        S_IDLE:   if (bus.enable && !bus.fifo_empty) state <= S_ACTIVE;
        S_ACTIVE: if (!bus.enable || bus.fifo_empty) state <= S_IDLE;
        S_ERROR:  state <= S_ERROR;
        default:  state <= S_RESET;
      endcase

      // A drop overrides any other transition and only reset leaves ERROR.
      if (drop) state <= S_ERROR;
    end
  end

  assign bus.fifo_rd   = rd_c;
  assign bus.push_out  = push_q;
  assign bus.data_out  = data_q;
  assign bus.words_fwd = fwd_q;
  assign bus.error     = error_q;
  assign bus.idle      = (state == S_IDLE) & ~rd_pending & (push_q == '0);

endmodule
